// File: rtl/rr_fifo_arbiter.sv
// Round-robin arbiter that drains four input FIFOs into one output FIFO.
// Pop is combinational; the popped word is pushed one cycle later with its grant index.
module rr_fifo_arbiter #(
  parameter int data_width = 10,
  parameter int num_inputs = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [num_inputs-1:0]            empty_in,
  input  logic [num_inputs-1:0]            error_in,
  input  logic [num_inputs*data_width-1:0] data_in,
  input  logic                             full_out,
  input  logic                             almost_full_out,
  output logic [num_inputs-1:0]            pop_out,
  output logic                             push_out,
  output logic [data_width-1:0]            data_out,
  output logic [1:0]                       grant_idx,
  output logic [1:0]                       state,
  output logic                             error
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    STALL  = 2'b10,
    ERROR  = 2'b11
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [1:0]            rr_ptr;
  logic                  pend;
  logic [num_inputs-1:0] req;
  logic                  stall;
  logic                  pop;
  logic                  found;
  logic                  err_now;
  logic [1:0]            sel;
  logic [1:0]            idx;

  assign state    = state_q;
  assign req      = ~empty_in;
  assign push_out = pend & (state_q != ERROR);
  assign data_out = push_out ? data_in[int'(grant_idx)*data_width +: data_width] : '0;

  // Blocking on almost_full only while a word is being pushed leaves room for the one in flight.
  assign stall = full_out | (almost_full_out & push_out);

  // Round-robin search starting at rr_ptr, wrapping past the top input.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < num_inputs; i++) begin
      idx = rr_ptr + 2'(i);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  // Reset gates pop so the input FIFOs are never popped while the arbiter is held.
  always_comb begin
    pop     = (state_q != ERROR) & found & ~stall & ~(|error_in) & ~reset;
    pop_out = pop ? (num_inputs'(1) << sel) : '0;
    err_now = (|error_in) | (|(pop_out & empty_in));
  end

  always_comb begin
    state_d = state_q;
    if (err_now) begin
      state_d = ERROR;
    end else begin
      case (state_q)
        IDLE:    if (found) state_d = stall ? STALL : ACTIVE;
        ACTIVE:  if (!found) state_d = IDLE;
                 else if (stall) state_d = STALL;
        STALL:   if (!stall) state_d = found ? ACTIVE : IDLE;
        default: state_d = ERROR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      pend      <= 1'b0;
      grant_idx <= '0;
      error     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (err_now) begin
        error <= 1'b1;
        pend  <= 1'b0;
      end else begin
        pend <= pop;
      end
      if (pop) begin
        grant_idx <= sel;
        rr_ptr    <= sel + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_rr_fifo_arbiter.sv
// Bench for rr_fifo_arbiter: FIFO models around the DUT, directed checks of
// pops and states, and a monitor scoring every push against an expected queue.
module tb_rr_fifo_arbiter;

  localparam int DW = 10;

  logic          clk;
  logic          reset;
  logic [3:0]    empty_in;
  logic [3:0]    error_in;
  logic [4*DW-1:0] data_in;
  logic          full_out;
  logic          almost_full_out;
  logic [3:0]    pop_out;
  logic          push_out;
  logic [DW-1:0] data_out;
  logic [1:0]    grant_idx;
  logic [1:0]    state;
  logic          error;

  int total = 0;
  int bad   = 0;
  logic [11:0] exp_q[$];

  rr_fifo_arbiter #(.data_width(DW), .num_inputs(4)) dut (
    .clk(clk), .reset(reset), .empty_in(empty_in), .error_in(error_in),
    .data_in(data_in), .full_out(full_out), .almost_full_out(almost_full_out),
    .pop_out(pop_out), .push_out(push_out), .data_out(data_out),
    .grant_idx(grant_idx), .state(state), .error(error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // input FIFO models: one-cycle read latency, empty derived from pointers
  bit [DW-1:0] mem[4][16];
  int          wr_ptr[4];
  int          rd_ptr[4];
  bit [DW-1:0] dreg[4];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop_out[i]) begin
        dreg[i]   <= mem[i][rd_ptr[i]];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      empty_in[i]         = (wr_ptr[i] == rd_ptr[i]);
      data_in[i*DW +: DW] = dreg[i];
    end
  end

  // output FIFO model, depth 4, drained one word per cycle when enabled
  int ocount = 0;
  bit drain_en;
  always @(posedge clk) begin
    ocount <= ocount + (push_out ? 1 : 0) - ((drain_en && ocount > 0) ? 1 : 0);
  end
  assign full_out        = (ocount >= 4);
  assign almost_full_out = (ocount >= 3);

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input logic [DW-1:0] w);
    mem[i][wr_ptr[i]] = w;
    wr_ptr[i] = wr_ptr[i] + 1;
  endtask

  task automatic expect_push(input logic [1:0] g, input logic [DW-1:0] w);
    exp_q.push_back({g, w});
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, want, $time);
    end
  endtask

  // scoreboard monitor
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (push_out) begin
        total++;
        if (full_out) begin
          bad++;
          $display("FAIL overflow push while full t=%0t", $time);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_push got=%0h t=%0t", {grant_idx, data_out}, $time);
        end else begin
          e = exp_q.pop_front();
          if ({grant_idx, data_out} !== e) begin
            bad++;
            $display("FAIL push_word got=%0h want=%0h t=%0t", {grant_idx, data_out}, e, $time);
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    logic [3:0] seq2 [8];
    seq2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset    = 1'b1;
    error_in = 4'b0;
    drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_ptr[i] = 0;
    end
    tick(); tick();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_pop", 16'(pop_out), 16'h0);
    chk("rst_push", 16'(push_out), 16'h0);
    chk("rst_data", 16'(data_out), 16'h0);
    chk("rst_grant", 16'(grant_idx), 16'h0);
    chk("rst_state", 16'(state), 16'h0);
    chk("rst_error", 16'(error), 16'h0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("idle_pop", 16'(pop_out), 16'h0);
      chk("idle_state", 16'(state), 16'h0);
    end

    // all four inputs with two words each
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      load(i, 10'h100 + 10'(i));
      load(i, 10'h200 + 10'(i));
    end
    for (int i = 0; i < 4; i++) expect_push(2'(i), 10'h100 + 10'(i));
    for (int i = 0; i < 4; i++) expect_push(2'(i), 10'h200 + 10'(i));
    #1;
    for (int c = 0; c < 8; c++) begin
      chk("rr_pop", 16'(pop_out), 16'(seq2[c]));
      tick();
    end
    chk("rr_tail_pop", 16'(pop_out), 16'h0);
    chk("rr_tail_push", 16'(push_out), 16'h1);
    tick();
    chk("rr_end_state", 16'(state), 16'h0);

    // move rr_ptr to 3, then a wrapping search onto input 2
    @(negedge clk);
    load(2, 10'h0AA);
    expect_push(2'd2, 10'h0AA);
    #1;
    chk("ptr_setup_pop", 16'(pop_out), 16'b0100);
    tick(); tick();
    @(negedge clk);
    load(2, 10'h300); load(2, 10'h301); load(2, 10'h302);
    expect_push(2'd2, 10'h300); expect_push(2'd2, 10'h301); expect_push(2'd2, 10'h302);
    #1;
    for (int c = 0; c < 3; c++) begin
      chk("wrap_pop", 16'(pop_out), 16'b0100);
      tick();
    end
    chk("wrap_empty_pop", 16'(pop_out), 16'h0);
    tick();
    @(negedge clk);
    load(0, 10'h0B0);
    load(3, 10'h0B3);
    expect_push(2'd3, 10'h0B3);
    expect_push(2'd0, 10'h0B0);
    #1;
    chk("ptr3_pop", 16'(pop_out), 16'b1000);
    tick();
    chk("ptr3_next_pop", 16'(pop_out), 16'b0001);
    tick(); tick(); tick(); tick();

    // back-pressure from the output FIFO
    @(negedge clk);
    drain_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      load(1, 10'h400 + 10'(k));
      expect_push(2'd1, 10'h400 + 10'(k));
    end
    #1;
    for (int c = 0; c < 4; c++) begin
      chk("bp_pop", 16'(pop_out), 16'b0010);
      tick();
    end
    chk("af_pop_blocked", 16'(pop_out), 16'h0);
    chk("af_push", 16'(push_out), 16'h1);
    chk("af_state", 16'(state), 16'h1);
    tick();
    chk("stall_state", 16'(state), 16'h2);
    chk("stall_push", 16'(push_out), 16'h0);
    chk("stall_pop", 16'(pop_out), 16'h0);
    tick();
    chk("full_push", 16'(push_out), 16'h0);
    chk("full_pop", 16'(pop_out), 16'h0);
    @(negedge clk);
    drain_en = 1'b1;
    tick();
    chk("resume_state", 16'(state), 16'h2);
    chk("resume_pop", 16'(pop_out), 16'b0010);
    tick(); tick(); tick(); tick();

    // error pulse during ACTIVE
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      load(0, 10'h050 + 10'(k));
      load(1, 10'h060 + 10'(k));
    end
    expect_push(2'd0, 10'h050);
    #1;
    chk("err_first_pop", 16'(pop_out), 16'b0001);
    tick();
    chk("err_active", 16'(state), 16'h1);
    @(negedge clk);
    error_in = 4'b0010;
    #1;
    chk("err_pop_suppressed", 16'(pop_out), 16'h0);
    tick();
    chk("err_flag", 16'(error), 16'h1);
    chk("err_state", 16'(state), 16'h3);
    @(negedge clk);
    error_in = 4'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("err_hold_pop", 16'(pop_out), 16'h0);
      chk("err_hold_push", 16'(push_out), 16'h0);
    end
    #1;
    reset = 1'b1;
    #1;
    chk("err_rst_state", 16'(state), 16'h0);
    chk("err_rst_error", 16'(error), 16'h0);
    chk("err_rst_pop", 16'(pop_out), 16'h0);
    chk("err_rst_push", 16'(push_out), 16'h0);
    @(negedge clk);
    reset = 1'b0;

    // reset mid-transfer, then restart from input 0
    expect_push(2'd0, 10'h051);
    #1;
    chk("rst2_pop0", 16'(pop_out), 16'b0001);
    tick();
    chk("rst2_pop1", 16'(pop_out), 16'b0010);
    tick();
    chk("rst2_pop2", 16'(pop_out), 16'b0001);
    chk("rst2_push_before", 16'(push_out), 16'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("rst2_push_async", 16'(push_out), 16'h0);
    chk("rst2_pop_async", 16'(pop_out), 16'h0);
    chk("rst2_state", 16'(state), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    expect_push(2'd0, 10'h052);
    expect_push(2'd1, 10'h061);
    expect_push(2'd1, 10'h062);
    #1;
    chk("restart_pop0", 16'(pop_out), 16'b0001);
    tick();
    chk("restart_pop1", 16'(pop_out), 16'b0010);
    tick();
    chk("restart_pop2", 16'(pop_out), 16'b0010);
    tick();
    chk("restart_done_pop", 16'(pop_out), 16'h0);
    tick(); tick(); tick();

    chk("exp_q_drained", 16'(exp_q.size()), 16'h0);
    chk("final_error", 16'(error), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
